gpr_write_arb: RTL and testbench
================================

# gpr_write_arb

Two-requester write-port arbiter and sequencer for the 8 x 8-bit general-purpose register file. It sits between two writeback sources (requester 0: ALU writeback, requester 1: load/immediate path) and the register file's single write port (data_in, destination select, gpr_load). It grants the port round-robin and drives exactly one single-cycle write per grant. It returns a one-cycle acknowledge to the winner.

## Interface
Parameters:
- DATA_W, 8, register data width; must match the register file.
- ADDR_W, 3, register select width; must match the register file (2**ADDR_W registers).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
- req0  in  1  requester 0 write request; held high with addr0/data0 stable until ack0.
- addr0  in  ADDR_W  requester 0 destination register.
- data0  in  DATA_W  requester 0 write data.
- ack0  out  1  one-cycle pulse: requester 0 write committed.
- req1  in  1  requester 1 write request; same rules as req0.
- addr1  in  ADDR_W  requester 1 destination register.
- data1  in  DATA_W  requester 1 write data.
- ack1  out  1  one-cycle pulse: requester 1 write committed.
- gpr_data_in  out  DATA_W  to register file data_in.
- gpr_rd_sel  out  ADDR_W  to register file destination select.
- gpr_load  out  1  to register file write enable; high exactly one cycle per write.
- busy  out  1  high in WRITE and ACK states.
- grant_id  out  1  requester owning the current or last grant.

## Operation
- All outputs are registered. Reset values: ack0=0, ack1=0, gpr_load=0, gpr_data_in=0, gpr_rd_sel=0, busy=0, grant_id=0. The priority pointer resets to 0, meaning requester 0 is favoured.
- State machine: IDLE -> WRITE -> ACK -> IDLE.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester named by the priority pointer.
  - On a grant: latch the winner's addr/data into gpr_rd_sel/gpr_data_in, set grant_id, and go to WRITE.
- WRITE:
  - gpr_load=1 for this single cycle, so the register file captures the data at the end of WRITE.
  - Always go to ACK.
- ACK:
  - ack of grant_id =1 for this single cycle; gpr_load=0.
  - Pointer becomes the other requester (~grant_id). Go to IDLE.
- gpr_data_in and gpr_rd_sel hold their last values outside WRITE. They change only on a new grant.
- A req still high in the IDLE cycle after its ack is treated as a new request.
- Requests arriving during WRITE/ACK are not sampled until IDLE.
- addr/data changes while req is high but before the grant are legal. Values are captured at the granting edge only.

## Timing
- Cycle numbering: req sampled high at edge N (state IDLE).
  - gpr_load high during cycle N..N+1.
  - Register written at edge N+1.
  - ack high during cycle N+1..N+2.
  - State is IDLE again after edge N+2.
- Latency from request to ack is 2 cycles. Throughput is one write per 3 cycles.
- Continuous contention from both requesters gives strict alternation: grants 0,1,0,1…, assuming the pointer is 0 at the start.
- Reset mid-operation: rst in WRITE or ACK forces IDLE at that edge.
  - gpr_load and ack are 0 the next cycle.
  - The transaction is dropped with no ack.
  - The requester keeps req high and is re-arbitrated after reset.
- rst has priority over all other inputs.

## Configuration
- GPR_ARB_R0_ZERO_EN defined:
  - A granted write with destination register 0 runs the full IDLE/WRITE/ACK sequence and is acknowledged normally.
  - gpr_load stays 0 during its WRITE cycle, so register 0 is never modified (hardwired-zero convention).
- GPR_ARB_R0_ZERO_EN undefined: register 0 is written like any other register.

## Test plan
- Reset: hold rst for 2 cycles with req0=req1=1 -> all outputs 0, no ack, state IDLE. After release, grant_id=0.
- Single write: req0=1, addr0=3'b001, data0=8'h8E -> gpr_load=1 with gpr_rd_sel=1 and gpr_data_in=8'h8E exactly one cycle later. ack0 follows one cycle after that. A register file readback of r1 returns 8'h8E.
- Contention: req0 and req1 held high with (addr 2, 8'h9B) and (addr 4, 8'h11) for 4 grants -> grant order 0,1,0,1 and ack0/ack1 alternate. r2=8'h9B, r4=8'h11.
- Reset mid-write: assert rst in the WRITE cycle of a req1 write to r5=8'hAA -> no ack1. The write recurs after reset release, and the exact number of writes to r5 is checked.
- Register-0 write: req0 with addr0=0, data0=8'hFF -> with GPR_ARB_R0_ZERO_EN, ack0 pulses, gpr_load never rises, and r0 is unchanged. Without the macro, r0=8'hFF.
- Back-to-back: req0 held high for 3 acks -> gpr_load pulses spaced 3 cycles apart and busy is low one cycle between grants.

Source files
------------

// File: rtl/gpr_write_arb.sv
// ---------------------------------------------------------------------------
// gpr_write_arb
//
// Round-robin write-port arbiter for the 8 x 8-bit general-purpose register
// file. Two writeback sources compete for the single write port. Each grant
// produces exactly one single-cycle register-file write followed by a
// one-cycle acknowledge to the winner. The sequence is
// IDLE -> WRITE -> ACK -> IDLE, and every output is registered.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req0/1       write request, held with addr/data until the matching ack
//   addr0/1      destination register of each requester
//   data0/1      write data of each requester
//   ack0/1       one-cycle pulse when that requester's write has committed
//   gpr_data_in  register file write data
//   gpr_rd_sel   register file destination select
//   gpr_load     register file write enable, one cycle per write
//   busy         high while in WRITE or ACK
//   grant_id     requester that owns the current or most recent grant
//
// Optional feature:
//   GPR_ARB_R0_ZERO_EN  when defined, a granted write to register 0 runs the
//                       full handshake and is acknowledged, but gpr_load is
//                       held low so r0 stays hardwired to its value.
// ---------------------------------------------------------------------------
module gpr_write_arb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic [DATA_W-1:0] gpr_data_in,
    output logic [ADDR_W-1:0] gpr_rd_sel,
    output logic              gpr_load,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              ptr;
    logic              ptr_next;
    logic              winner;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              zero_dest;
    logic              ack0_next;
    logic              ack1_next;
    logic              load_next;
    logic              busy_next;
    logic              grant_next;
    logic [DATA_W-1:0] data_next;
    logic [ADDR_W-1:0] sel_next;

    // The pointer only matters under contention. A lone request wins outright,
    // so req1 alone selects 1 and req0 alone selects 0.
    always_comb begin
        winner   = (req0 && req1) ? ptr : req1;
        win_addr = winner ? addr1 : addr0;
        win_data = winner ? data1 : data0;
    end

`ifdef GPR_ARB_R0_ZERO_EN
    assign zero_dest = (win_addr == '0);
`else
    assign zero_dest = 1'b0;
`endif

    // State and registered outputs. The outputs are computed one cycle early
    // by the output logic so that they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            gpr_load    <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= 1'b0;
            gpr_data_in <= '0;
            gpr_rd_sel  <= '0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            ack0        <= ack0_next;
            ack1        <= ack1_next;
            gpr_load    <= load_next;
            busy        <= busy_next;
            grant_id    <= grant_next;
            gpr_data_in <= data_next;
            gpr_rd_sel  <= sel_next;
        end
    end

    // Next-state logic. WRITE and ACK are fixed single-cycle states.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req0 || req1) state_next = WRITE;
            WRITE:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic, producing the values for the state being entered.
    // Address and data are captured only at the granting edge and otherwise
    // hold, so the register file sees stable values outside WRITE. The
    // pointer hands priority to the other requester once the ack is issued.
    always_comb begin
        ack0_next  = 1'b0;
        ack1_next  = 1'b0;
        load_next  = 1'b0;
        busy_next  = 1'b0;
        grant_next = grant_id;
        data_next  = gpr_data_in;
        sel_next   = gpr_rd_sel;
        ptr_next   = ptr;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_next = winner;
                    sel_next   = win_addr;
                    data_next  = win_data;
                    busy_next  = 1'b1;
                    load_next  = !zero_dest;
                end
            end
            WRITE: begin
                busy_next = 1'b1;
                ack0_next = !grant_id;
                ack1_next = grant_id;
            end
            ACK: begin
                ptr_next = !grant_id;
            end
            default: begin
                ptr_next = ptr;
            end
        endcase
    end

endmodule

// File: tb/tb_gpr_write_arb.sv
// ---------------------------------------------------------------------------
// tb_gpr_write_arb
//
// Directed and randomized bench for gpr_write_arb. A small register file is
// driven from the DUT's write port so that writes can be read back. The
// reference model tracks each transaction as "cycles since grant" and derives
// every expected output and register value from that count.
// Honours GPR_ARB_R0_ZERO_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_gpr_write_arb;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [DATA_W-1:0] data0 = '0;
    logic              ack0;
    logic              req1 = 1'b0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [DATA_W-1:0] data1 = '0;
    logic              ack1;
    logic [DATA_W-1:0] gpr_data_in;
    logic [ADDR_W-1:0] gpr_rd_sel;
    logic              gpr_load;
    logic              busy;
    logic              grant_id;

    gpr_write_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .addr0       (addr0),
        .data0       (data0),
        .ack0        (ack0),
        .req1        (req1),
        .addr1       (addr1),
        .data1       (data1),
        .ack1        (ack1),
        .gpr_data_in (gpr_data_in),
        .gpr_rd_sel  (gpr_rd_sel),
        .gpr_load    (gpr_load),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT's write port; never reset.
    logic [7:0] rf [8] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    int         w5_actual = 0;

    always @(posedge clk) begin
        if (gpr_load === 1'b1) begin
            rf[gpr_rd_sel] <= gpr_data_in;
            if (gpr_rd_sel == 3'd5) w5_actual <= w5_actual + 1;
        end
    end

    // Reference model state: m_phase counts cycles since the grant
    // (0 = no transaction, 1 = write cycle, 2 = ack cycle).
    int         m_phase = 0;
    logic       m_ptr = 1'b0;
    logic       m_gid = 1'b0;
    logic [2:0] m_sel = '0;
    logic [7:0] m_data = '0;
    logic       m_load = 1'b0;
    logic       m_ack0 = 1'b0;
    logic       m_ack1 = 1'b0;
    logic       m_busy = 1'b0;
    logic [7:0] exp_rf [8] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    int         w5_expected = 0;

    int n_compared = 0;
    int n_mismatched = 0;
    int cycle = 0;
    bit drop0 = 1'b1;
    bit drop1 = 1'b1;

    function automatic bit r0_blocked(input logic [2:0] sel);
`ifdef GPR_ARB_R0_ZERO_EN
        return (sel == 3'd0);
`else
        return (sel != sel);
`endif
    endfunction

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, observed, expected, cycle);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        if (m_load) begin
            exp_rf[m_sel] = m_data;
            if (m_sel == 3'd5) w5_expected++;
        end
        if (rst) begin
            m_phase = 0;
            m_ptr   = 1'b0;
            m_gid   = 1'b0;
            m_sel   = '0;
            m_data  = '0;
        end else if (m_phase == 0) begin
            if (req0 || req1) begin
                m_gid   = (req0 && req1) ? m_ptr : req1;
                m_sel   = m_gid ? addr1 : addr0;
                m_data  = m_gid ? data1 : data0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_ptr   = !m_gid;
            m_phase = 0;
        end
        m_load = (m_phase == 1) && !r0_blocked(m_sel);
        m_ack0 = (m_phase == 2) && (m_gid == 1'b0);
        m_ack1 = (m_phase == 2) && (m_gid == 1'b1);
        m_busy = (m_phase != 0);
    endtask

    task automatic check_all();
        check_output("ack0", 8'(ack0), 8'(m_ack0));
        check_output("ack1", 8'(ack1), 8'(m_ack1));
        check_output("gpr_load", 8'(gpr_load), 8'(m_load));
        check_output("busy", 8'(busy), 8'(m_busy));
        check_output("grant_id", 8'(grant_id), 8'(m_gid));
        check_output("gpr_rd_sel", 8'(gpr_rd_sel), 8'(m_sel));
        check_output("gpr_data_in", gpr_data_in, m_data);
    endtask

    // One clock: model update at the edge, output check 1 ns later, then
    // requesters whose ack is showing release their request if asked to.
    task automatic apply_stimulus();
        @(posedge clk);
        model_step();
        cycle++;
        #1;
        check_all();
        if (m_ack0 && drop0) req0 = 1'b0;
        if (m_ack1 && drop1) req1 = 1'b0;
    endtask

    logic grants [$];
    logic exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int   load_cycles [$];
    int   busy_low;
    int   w5_base_a;
    int   w5_base_e;
    logic [7:0] exp_r0;

    initial begin
        $display("[TB] start");

        // Reset held two cycles with both requests high.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        addr0 = 3'd6; data0 = 8'h66; addr1 = 3'd7; data1 = 8'h77;
        apply_stimulus();
        apply_stimulus();
        check_output("reset_ack0", 8'(ack0), 8'h00);
        check_output("reset_load", 8'(gpr_load), 8'h00);
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
        apply_stimulus();
        check_output("post_reset_grant_id", 8'(grant_id), 8'h00);

        // Single write r1 = 8E from requester 0.
        req0 = 1'b1; addr0 = 3'd1; data0 = 8'h8E;
        apply_stimulus();
        check_output("single_load", 8'(gpr_load), 8'h01);
        check_output("single_sel", 8'(gpr_rd_sel), 8'h01);
        check_output("single_data", gpr_data_in, 8'h8E);
        apply_stimulus();
        check_output("single_ack0", 8'(ack0), 8'h01);
        apply_stimulus();
        apply_stimulus();
        check_output("single_r1", rf[1], 8'h8E);

        // Contention from a freshly reset pointer: expect 0,1,0,1.
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        drop0 = 1'b0; drop1 = 1'b0;
        req0 = 1'b1; addr0 = 3'd2; data0 = 8'h9B;
        req1 = 1'b1; addr1 = 3'd4; data1 = 8'h11;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus();
            if (ack0 || ack1) grants.push_back(grant_id);
        end
        req0 = 1'b0; req1 = 1'b0; drop0 = 1'b1; drop1 = 1'b1;
        apply_stimulus();
        check_output("contention_grants", 8'(grants.size()), 8'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check_output("contention_order", 8'(grants[i]), 8'(exp_order[i]));
        check_output("contention_r2", rf[2], 8'h9B);
        check_output("contention_r4", rf[4], 8'h11);

        // Reset during the WRITE cycle of a requester 1 write to r5. The write
        // enable is already high at that edge, so r5 is written once there and
        // once more when the held request is re-granted.
        w5_base_a = w5_actual;
        w5_base_e = w5_expected;
        req1 = 1'b1; addr1 = 3'd5; data1 = 8'hAA;
        apply_stimulus();
        rst = 1'b1;
        apply_stimulus();
        check_output("midwrite_no_ack1", 8'(ack1), 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus();
        check_output("midwrite_r5_writes", 8'(w5_actual - w5_base_a),
                     8'(w5_expected - w5_base_e));
        check_output("midwrite_r5", rf[5], 8'hAA);

        // Write to register 0.
        req0 = 1'b1; addr0 = 3'd0; data0 = 8'hFF;
        for (int i = 0; i < 4; i++) apply_stimulus();
`ifdef GPR_ARB_R0_ZERO_EN
        exp_r0 = 8'h50;
`else
        exp_r0 = 8'hFF;
`endif
        check_output("r0_value", rf[0], exp_r0);

        // Back-to-back requests from requester 0 held for three acks.
        drop0 = 1'b0;
        req0 = 1'b1; addr0 = 3'd3; data0 = 8'h3C;
        busy_low = 0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus();
            if (gpr_load) load_cycles.push_back(cycle);
            if (!busy) busy_low++;
        end
        req0 = 1'b0; drop0 = 1'b1;
        apply_stimulus();
        check_output("b2b_loads", 8'(load_cycles.size()), 8'd3);
        for (int i = 1; i < load_cycles.size(); i++)
            check_output("b2b_spacing", 8'(load_cycles[i] - load_cycles[i-1]), 8'd3);
        check_output("b2b_busy_low", 8'(busy_low), 8'd3);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drop0 = 1'($urandom_range(0, 1));
            drop1 = 1'($urandom_range(0, 1));
            if (!req0) begin
                if ($urandom_range(0, 2) == 0) begin
                    req0 = 1'b1; addr0 = 3'($urandom); data0 = 8'($urandom);
                end
            end else if (!(m_phase != 0 && m_gid == 1'b0) && $urandom_range(0, 3) == 0) begin
                addr0 = 3'($urandom); data0 = 8'($urandom);
            end
            if (!req1) begin
                if ($urandom_range(0, 2) == 0) begin
                    req1 = 1'b1; addr1 = 3'($urandom); data1 = 8'($urandom);
                end
            end else if (!(m_phase != 0 && m_gid == 1'b1) && $urandom_range(0, 3) == 0) begin
                addr1 = 3'($urandom); data1 = 8'($urandom);
            end
            apply_stimulus();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus();
        for (int r = 0; r < 8; r++) check_output("final_rf", rf[r], exp_rf[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
